// File: rtl/mdu_if.sv
// Handshake/data bundle between the execute stage and the iterative multiply/divide unit.
interface mdu_if #(
    parameter int XLEN = 32
);
    logic            start_i;
    logic [2:0]      op_i;
    logic [XLEN-1:0] data1_i;
    logic [XLEN-1:0] data2_i;
    logic            flush_i;
    logic [XLEN-1:0] result_o;
    logic            ready_o;
    logic            busy_o;

    modport master (
        output start_i, op_i, data1_i, data2_i, flush_i,
        input  result_o, ready_o, busy_o
    );

    modport slave (
        input  start_i, op_i, data1_i, data2_i, flush_i,
        output result_o, ready_o, busy_o
    );
endinterface

// File: rtl/mdu_iter.sv
// Iterative RISC-V M-extension unit: radix-2 shift-add multiply and restoring divide,
// one bit per cycle, with a one-cycle fast path for divide-by-zero and signed overflow.
module mdu_iter #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN + 1)
) (
    input  logic  clk,
    input  logic  rst_n,
    mdu_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [XLEN-1:0]   ONE_X  = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]   ZERO_X = {XLEN{1'b0}};
    localparam logic [XLEN-1:0]   ONES_X = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]   MIN_X  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [2*XLEN-1:0] ONE_2X = {{(2*XLEN-1){1'b0}}, 1'b1};

    function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v);
        return ~v + ONE_X;
    endfunction

    function automatic logic [2*XLEN-1:0] neg_2x(input logic [2*XLEN-1:0] v);
        return ~v + ONE_2X;
    endfunction

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [2:0]          r_op;
    logic                r_neg;
    logic [XLEN-1:0]     r_a;
    logic [XLEN-1:0]     r_b;
    logic [XLEN-1:0]     r_rem;
    logic [2*XLEN-1:0]   r_acc;
    logic [XLEN-1:0]     r_result;
    logic                r_ready;
    logic                r_busy;

    logic                w_accept;
    logic                w_complete;
    logic                w_s1_sgn;
    logic                w_s2_sgn;
    logic                w_n1;
    logic                w_n2;
    logic                w_neg_ld;
    logic [XLEN-1:0]     w_mag1;
    logic [XLEN-1:0]     w_mag2;
    logic                w_is_div;
    logic                w_div0;
    logic                w_ovf;
    logic                w_fast;
    logic [XLEN:0]       w_mul_sum;
    logic [XLEN:0]       w_div_shift;
    logic [XLEN:0]       w_div_diff;
    logic [2*XLEN-1:0]   w_prod;
    logic [XLEN-1:0]     w_quo;
    logic [XLEN-1:0]     w_remv;
    logic [XLEN-1:0]     w_res;

    // Operand signedness, magnitudes, result sign and fast-path detection for the incoming op
    always_comb begin
        w_s1_sgn = 1'b0;
        w_s2_sgn = 1'b0;
        case (bus.op_i)
            3'd0, 3'd1, 3'd4, 3'd6: begin
                w_s1_sgn = 1'b1;
                w_s2_sgn = 1'b1;
            end
            3'd2: begin
                w_s1_sgn = 1'b1;
                w_s2_sgn = 1'b0;
            end
            default: begin
                w_s1_sgn = 1'b0;
                w_s2_sgn = 1'b0;
            end
        endcase
        w_n1     = w_s1_sgn & bus.data1_i[XLEN-1];
        w_n2     = w_s2_sgn & bus.data2_i[XLEN-1];
        w_mag1   = w_n1 ? neg_x(bus.data1_i) : bus.data1_i;
        w_mag2   = w_n2 ? neg_x(bus.data2_i) : bus.data2_i;
        // Remainder takes the dividend's sign; product and quotient take the XOR
        w_neg_ld = (bus.op_i == 3'd6) ? w_n1 : (w_n1 ^ w_n2);
        w_is_div = bus.op_i[2];
        w_div0   = w_is_div & (bus.data2_i == ZERO_X);
        w_ovf    = w_is_div & ~bus.op_i[0] & (bus.data1_i == MIN_X) & (bus.data2_i == ONES_X);
        w_fast   = w_div0 | w_ovf;
    end

    // One iteration of shift-add multiply and restoring divide, plus final sign fix-up and select
    always_comb begin
        w_mul_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_a} : {(XLEN+1){1'b0}});
        w_div_shift = {r_rem, r_acc[XLEN-1]};
        w_div_diff  = w_div_shift - {1'b0, r_b};
        w_prod      = r_neg ? neg_2x(r_acc) : r_acc;
        w_quo       = r_neg ? neg_x(r_acc[XLEN-1:0]) : r_acc[XLEN-1:0];
        w_remv      = r_neg ? neg_x(r_rem) : r_rem;
        case (r_op)
            3'd0:             w_res = w_prod[XLEN-1:0];
            3'd1, 3'd2, 3'd3: w_res = w_prod[2*XLEN-1:XLEN];
            3'd4, 3'd5:       w_res = w_quo;
            default:          w_res = w_remv;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; flush overrides everything and suppresses launch and completion
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_complete  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.flush_i) begin
                    w_state_nxt = S_IDLE;
                end else if (bus.start_i) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_fast ? S_DONE : S_CALC;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CALC: begin
                if (bus.flush_i) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_CALC;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                if (bus.flush_i) begin
                    w_complete = 1'b0;
                end else begin
                    w_complete = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: operand latch / fast-path preload on launch, one bit per CALC cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= {CNT_W{1'b0}};
            r_op  <= 3'd0;
            r_neg <= 1'b0;
            r_a   <= ZERO_X;
            r_b   <= ZERO_X;
            r_rem <= ZERO_X;
            r_acc <= {(2*XLEN){1'b0}};
        end else if (w_accept) begin
            r_op <= bus.op_i;
            r_a  <= w_mag1;
            r_b  <= w_mag2;
            if (w_fast) begin
                r_cnt <= {CNT_W{1'b0}};
                r_neg <= 1'b0;
                r_acc <= {ZERO_X, (w_div0 ? ONES_X : bus.data1_i)};
                r_rem <= w_div0 ? bus.data1_i : ZERO_X;
            end else begin
                r_cnt <= CNT_W'(XLEN);
                r_neg <= w_neg_ld;
                r_acc <= {ZERO_X, (w_is_div ? w_mag1 : w_mag2)};
                r_rem <= ZERO_X;
            end
        end else if (r_state == S_CALC) begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_op[2]) begin
                if (!w_div_diff[XLEN]) begin
                    r_rem             <= w_div_diff[XLEN-1:0];
                    r_acc[XLEN-1:0]   <= {r_acc[XLEN-2:0], 1'b1};
                end else begin
                    r_rem             <= w_div_shift[XLEN-1:0];
                    r_acc[XLEN-1:0]   <= {r_acc[XLEN-2:0], 1'b0};
                end
            end else begin
                r_acc <= {w_mul_sum, r_acc[XLEN-1:1]};
            end
        end
    end

    // Registered outputs; busy covers the completion cycle so it drops together with ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= ZERO_X;
            r_ready  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_ready <= w_complete;
            r_busy  <= (w_state_nxt != S_IDLE) | w_complete;
            if (w_complete) begin
                r_result <= w_res;
            end
        end
    end

    assign bus.result_o = r_result;
    assign bus.ready_o  = r_ready;
    assign bus.busy_o   = r_busy;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter at XLEN=32 and XLEN=16 against an arithmetic reference model.
module tb_mdu_iter;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_cmp = 0;
    int   n_fail = 0;
    logic [31:0] last32 = 32'd0;

    always #5 clk = ~clk;

    mdu_if #(.XLEN(32)) if32 ();
    mdu_if #(.XLEN(16)) if16 ();

    mdu_iter #(.XLEN(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(if32.slave));
    mdu_iter #(.XLEN(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));

    // RISC-V M semantics computed with wide integer arithmetic
    function automatic logic [31:0] ref_mdu(input int w, input logic [2:0] op,
                                            input logic [31:0] a, input logic [31:0] b);
        longint mask, ua, ub, sa, sb, r, smin;
        logic [63:0] pu;
        bit ovf;
        mask = (longint'(1) <<< w) - 1;
        smin = -(longint'(1) <<< (w - 1));
        ua   = longint'({32'd0, a}) & mask;
        ub   = longint'({32'd0, b}) & mask;
        sa   = (ua >= (longint'(1) <<< (w - 1))) ? ua - (longint'(1) <<< w) : ua;
        sb   = (ub >= (longint'(1) <<< (w - 1))) ? ub - (longint'(1) <<< w) : ub;
        pu   = unsigned'(ua) * unsigned'(ub);
        ovf  = (sa == smin) && (sb == -1);
        case (op)
            3'd0:    r = sa * sb;
            3'd1:    r = (sa * sb) >>> w;
            3'd2:    r = (sa * ub) >>> w;
            3'd3:    r = longint'(pu >> w);
            3'd4:    r = (ub == 0) ? mask : (ovf ? ua : sa / sb);
            3'd5:    r = (ub == 0) ? mask : ua / ub;
            3'd6:    r = (ub == 0) ? ua : (ovf ? 0 : sa % sb);
            default: r = (ub == 0) ? ua : ua % ub;
        endcase
        return 32'(r & mask);
    endfunction

    function automatic int ref_lat(input int w, input logic [2:0] op,
                                   input logic [31:0] a, input logic [31:0] b);
        longint mask, ua, ub;
        mask = (longint'(1) <<< w) - 1;
        ua   = longint'({32'd0, a}) & mask;
        ub   = longint'({32'd0, b}) & mask;
        if (op >= 3'd4 && ub == 0) return 1;
        if ((op == 3'd4 || op == 3'd6) && ua == (longint'(1) <<< (w - 1)) && ub == mask) return 1;
        return w + 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit s16, input logic st, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        if (s16) begin
            if16.start_i = st; if16.op_i = op; if16.data1_i = a[15:0]; if16.data2_i = b[15:0];
        end else begin
            if32.start_i = st; if32.op_i = op; if32.data1_i = a; if32.data2_i = b;
        end
    endtask

    function automatic logic [31:0] get_res(input bit s16);
        return s16 ? {16'd0, if16.result_o} : if32.result_o;
    endfunction
    function automatic logic get_rdy(input bit s16);
        return s16 ? if16.ready_o : if32.ready_o;
    endfunction
    function automatic logic get_busy(input bit s16);
        return s16 ? if16.busy_o : if32.busy_o;
    endfunction

    // Launch one op, optionally re-assert start with other operands while busy, then check it
    task automatic run_op(input bit s16, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat,
                          input int poke, input string tag);
        int n;
        bit seen;
        bit busy_ok;
        @(negedge clk);
        drive(s16, 1'b1, op, a, b);
        @(posedge clk);
        #1;
        drive(s16, 1'b0, 3'($urandom_range(7)), $urandom, $urandom);
        n = 0; seen = 1'b0; busy_ok = get_busy(s16);
        while (!seen && n < 200) begin
            @(posedge clk);
            n++;
            #1;
            if (poke > 0 && n == poke) drive(s16, 1'b1, ~op, ~a, b + 32'd1);
            else if (poke > 0 && n == poke + 3) drive(s16, 1'b0, op, a, b);
            seen = get_rdy(s16);
            busy_ok = busy_ok & get_busy(s16);
        end
        check({tag, "/latency"}, 32'(n), 32'(lat));
        check({tag, "/result"}, get_res(s16), exp);
        check({tag, "/busy"}, {31'd0, busy_ok}, 32'd1);
        @(posedge clk);
        #1;
        check({tag, "/ready_pulse"}, {31'd0, get_rdy(s16)}, 32'd0);
        check({tag, "/busy_drop"}, {31'd0, get_busy(s16)}, 32'd0);
        if (!s16) last32 = exp;
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        int          n_rdy;
        drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
        if32.flush_i = 1'b0;
        if16.flush_i = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset/result", if32.result_o, 32'd0);
        check("reset/ready", {31'd0, if32.ready_o}, 32'd0);
        check("reset/busy", {31'd0, if32.busy_o}, 32'd0);
        check("reset16/busy", {31'd0, if16.busy_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(1'b0, 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 0, "mul");
        run_op(1'b0, 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 0, "mulh");
        run_op(1'b0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0, "mulhu");
        run_op(1'b0, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 0, "mulhsu");
        run_op(1'b0, 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0, "div_neg");
        run_op(1'b0, 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0, "rem_neg");
        run_op(1'b0, 3'd6, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, 0, "rem_posdvd");
        run_op(1'b0, 3'd6, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 33, 0, "rem_negneg");
        run_op(1'b0, 3'd5, 32'd100, 32'd7, 32'd14, 33, 0, "divu");
        run_op(1'b0, 3'd7, 32'd100, 32'd7, 32'd2, 33, 0, "remu");
        run_op(1'b0, 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0, "div_by0");
        run_op(1'b0, 3'd6, 32'd5, 32'd0, 32'd5, 1, 0, "rem_by0");
        run_op(1'b0, 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0, "divu_by0");
        run_op(1'b0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, "div_ovf");
        run_op(1'b0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0, "rem_ovf");
        run_op(1'b0, 3'd5, 32'd1000, 32'd3, 32'd333, 33, 5, "start_busy");

        // Flush ten cycles into a divide
        @(negedge clk);
        drive(1'b0, 1'b1, 3'd4, 32'd1000, 32'd7);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        if32.flush_i = 1'b1;
        @(posedge clk);
        #1;
        if32.flush_i = 1'b0;
        check("flush/busy", {31'd0, if32.busy_o}, 32'd0);
        check("flush/ready", {31'd0, if32.ready_o}, 32'd0);
        check("flush/result", if32.result_o, last32);
        n_rdy = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (if32.ready_o) n_rdy++;
        end
        check("flush/no_ready", 32'(n_rdy), 32'd0);

        // Flush coincident with start in IDLE wins
        @(negedge clk);
        drive(1'b0, 1'b1, 3'd0, 32'd3, 32'd3);
        if32.flush_i = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        if32.flush_i = 1'b0;
        check("flush_start/busy", {31'd0, if32.busy_o}, 32'd0);

        // Reset in the middle of a multiply
        @(negedge clk);
        drive(1'b0, 1'b1, 3'd0, 32'd11, 32'd13);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid/result", if32.result_o, 32'd0);
        check("rst_mid/ready", {31'd0, if32.ready_o}, 32'd0);
        check("rst_mid/busy", {31'd0, if32.busy_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        last32 = 32'd0;
        run_op(1'b0, 3'd0, 32'd11, 32'd13, 32'd143, 33, 0, "after_rst");

        // Randomized ops at XLEN=32 with boundary-biased operands
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(9))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(20, 1));
                3: a = 32'($urandom_range(50));
                default: b = $urandom;
            endcase
            run_op(1'b0, op, a, b, ref_mdu(32, op, a, b), ref_lat(32, op, a, b), 0, "rand32");
        end

        run_op(1'b1, 3'd3, 32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_FFFE, 17, 0, "mulhu16");
        run_op(1'b1, 3'd4, 32'h0000_8000, 32'h0000_FFFF, 32'h0000_8000, 1, 0, "div_ovf16");

        // Randomized ops at XLEN=16
        for (int i = 0; i < 30; i++) begin
            op = 3'($urandom_range(7));
            a  = {16'd0, 16'($urandom)};
            b  = {16'd0, 16'($urandom)};
            case ($urandom_range(7))
                0: b = 32'd0;
                1: begin a = 32'h0000_8000; b = 32'h0000_FFFF; end
                2: b = 32'($urandom_range(9, 1));
                default: b = {16'd0, 16'($urandom)};
            endcase
            run_op(1'b1, op, a, b, ref_mdu(16, op, a, b), ref_lat(16, op, a, b), 0, "rand16");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Parametrised, iterative multiply/divide unit for the RISC-V M extension (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU). It is the multi-cycle successor to the single-cycle combinational ALU and sits beside it in the execute stage. The pipeline launches one operation with a start pulse, holds while `busy_o` is high, and collects the registered result on a one-cycle `ready_o` pulse. The width is generic and the unit supports abort (flush).

## Interface
- `XLEN`, 32: operand and result width (≥ 8).
- `CNT_W`, $clog2(XLEN+1): iteration counter width.

- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start_i` in 1: launch request; sampled only in IDLE.
- `op_i` in 3: RISC-V funct3. 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `data1_i` in XLEN: rs1 (multiplicand / dividend).
- `data2_i` in XLEN: rs2 (multiplier / divisor).
- `flush_i` in 1: synchronous abort; highest priority after reset.
- `result_o` out XLEN: registered result; holds until the next completion.
- `ready_o` out 1: one-cycle completion pulse; `result_o` is valid in the same cycle.
- `busy_o` out 1: high whenever state ≠ IDLE.

## Operation
- **States:** IDLE, CALC, DONE.
- **IDLE**
  - `start_i`=1 and `flush_i`=0: latch `op_i` and the operands. Inputs are don't-care afterwards.
  - Special-case fast path goes directly to DONE:
    - Divide by zero (`data2_i`=0, op 4–7): quotient = all ones; remainder = dividend.
    - Signed overflow (op 4/6, dividend = 1<<(XLEN-1), divisor = all ones): quotient = dividend; remainder = 0.
  - Otherwise go to CALC with counter = XLEN.
- **Operand conditioning**
  - Signed operands are converted to magnitude.
    - rs1 is signed for MUL, MULH, MULHSU, DIV, REM.
    - rs2 is signed for MUL, MULH, DIV, REM.
  - Negate flag:
    - Multiply: s1 XOR s2.
    - Quotient: s1 XOR s2.
    - Remainder: s1.
- **CALC** (one bit per cycle, counter decrements; at counter = 1 go to DONE)
  - Multiply: radix-2 shift-add into a 2·XLEN accumulator.
  - Divide: restoring division with an (XLEN+1)-bit partial remainder.
- **DONE**
  - Apply the two's-complement negate if flagged.
  - Select the result:
    - MUL: low XLEN bits.
    - MULH/MULHSU/MULHU: high XLEN bits.
    - DIV/DIVU: quotient.
    - REM/REMU: remainder.
  - Register the result into `result_o`, pulse `ready_o`, and return to IDLE.
  - Fast-path results are registered in the same DONE cycle.
- **Start while busy:** `start_i` is ignored. No queuing.
- **`flush_i`=1 in any state:** next edge returns to IDLE.
  - No `ready_o` pulse.
  - `result_o` is unchanged.
  - Flush wins over a coincident `start_i`.
  - Flush in DONE suppresses that completion.
- **Reset (any time, including mid-operation):**
  - State IDLE, `result_o`=0, `ready_o`=0, `busy_o`=0, counter=0.
  - Internal operand/accumulator registers are cleared.

## Timing
- Start is accepted at edge E0, where `start_i` is sampled high in IDLE.
- Normal ops:
  - `busy_o` is high from E0 onward.
  - XLEN CALC cycles, then DONE.
  - `ready_o` is high in the cycle following edge E0+XLEN+1, so latency is XLEN+1 cycles (33 for XLEN=32).
  - `busy_o` drops at the same edge that deasserts `ready_o`.
- Fast path: `ready_o` follows E0+1 (latency 1).
- Back-to-back: a new start may be asserted in the cycle after `ready_o` (IDLE). Throughput is one op per XLEN+2 cycles.
- `ready_o` is never high for more than one consecutive cycle.

## Test plan
- **Multiply latency:** MUL, `data1_i`=7, `data2_i`=0xFFFFFFFD (−3) -> `result_o`=0xFFFFFFEB; `ready_o` exactly 33 cycles after the start edge; `busy_o` high for those cycles.
- **High-word multiplies:**
  - MULH 0x80000000×0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
- **Divide/remainder:**
  - DIV −7/2 -> 0xFFFFFFFD; REM −7%2 -> 0xFFFFFFFF.
  - DIVU 100/7 -> 14; REMU 100%7 -> 2.
  - Sign of a nonzero remainder matches the dividend.
- **Special cases:**
  - DIV 5/0 -> 0xFFFFFFFF; REM 5%0 -> 5; DIVU 5/0 -> 0xFFFFFFFF.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
  - All of these complete with latency 1.
- **Control:**
  - `flush_i` pulsed 10 cycles into a DIV: `busy_o` low next cycle, no `ready_o`, `result_o` keeps the prior value.
  - `start_i` with new operands while busy is ignored; the original result is returned.
  - `rst_n` asserted mid-CALC: all outputs 0 immediately.
- **Parameter sweep (XLEN=16):**
  - MULHU 0xFFFF×0xFFFF -> 0xFFFE, latency 17.
  - DIV 0x8000/0xFFFF -> 0x8000.
